// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, control bundle and helpers for the pipelined control/hazard unit.
package pipe_ctrl_pkg;

    localparam int ALU_W = 6;
    localparam int RA_W  = 5;

    localparam logic [ALU_W-1:0] ALU_ADDU = 6'd0;
    localparam logic [ALU_W-1:0] ALU_SUBU = 6'd1;
    localparam logic [ALU_W-1:0] ALU_ADD  = 6'd2;
    localparam logic [ALU_W-1:0] ALU_AND  = 6'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 6'd4;
    localparam logic [ALU_W-1:0] ALU_SLT  = 6'd5;
    localparam logic [ALU_W-1:0] ALU_LUI  = 6'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_JUMP = 2'b01;
    localparam logic [1:0] NPC_JR   = 2'b10;
    localparam logic [1:0] NPC_BR   = 2'b11;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_LINK = 2'b10;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic             is_load;
        logic             is_bne;
        logic             s_b;
        logic [1:0]       s_npc;
        logic [ALU_W-1:0] alu_ctrl;
        logic [1:0]       s_data_write;
        logic [RA_W-1:0]  waddr;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        reg_write:    1'b0,
        mem_write:    1'b0,
        is_load:      1'b0,
        is_bne:       1'b0,
        s_b:          1'b0,
        s_npc:        NPC_SEQ,
        alu_ctrl:     ALU_ADD,
        s_data_write: WD_ALU,
        waddr:        '0
    };

    // The younger producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input ctrl_t ex, input ctrl_t mem);
        if (ex.reg_write && ex.waddr == src)
            return 2'b01;
        if (mem.reg_write && mem.waddr == src)
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic src_hit(input logic used, input logic [RA_W-1:0] src,
                                     input ctrl_t stage);
        return used && stage.reg_write && stage.waddr == src;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational ID-stage decoder: instruction word to control bundle and source usage.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        s_ext,
    output logic        use_rs,
    output logic        use_rt
);

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic            unused_bits;

    assign op          = instr[31:26];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign funct       = instr[5:0];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        ctrl   = BUBBLE;
        s_ext  = 1'b1;
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.waddr     = rd;
                use_rs         = 1'b1;
                use_rt         = 1'b1;
                case (funct)
                    FN_ADDU: ctrl.alu_ctrl = ALU_ADDU;
                    FN_SUBU: ctrl.alu_ctrl = ALU_SUBU;
                    FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                    FN_AND:  ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.waddr     = '0;
                        ctrl.s_npc     = NPC_JR;
                        use_rt         = 1'b0;
                    end
                    default: begin
                        ctrl   = BUBBLE;
                        use_rs = 1'b0;
                        use_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.waddr     = rt;
                ctrl.s_b       = 1'b1;
                use_rs         = (op != OP_LUI);
                s_ext          = !(op == OP_ANDI || op == OP_ORI || op == OP_LUI);
                case (op)
                    OP_ADDI:  ctrl.alu_ctrl = ALU_ADD;
                    OP_ADDIU: ctrl.alu_ctrl = ALU_ADDU;
                    OP_ANDI:  ctrl.alu_ctrl = ALU_AND;
                    OP_ORI:   ctrl.alu_ctrl = ALU_OR;
                    OP_LUI:   ctrl.alu_ctrl = ALU_LUI;
                    default: begin
                        ctrl.alu_ctrl     = ALU_ADDU;
                        ctrl.is_load      = 1'b1;
                        ctrl.s_data_write = WD_MEM;
                    end
                endcase
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.s_b       = 1'b1;
                ctrl.alu_ctrl  = ALU_ADDU;
                use_rs         = 1'b1;
                use_rt         = 1'b1;
            end
            OP_J: ctrl.s_npc = NPC_JUMP;
            OP_JAL: begin
                ctrl.s_npc        = NPC_JUMP;
                ctrl.reg_write    = 1'b1;
                ctrl.waddr        = 5'd31;
                ctrl.s_data_write = WD_LINK;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.s_npc    = NPC_BR;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.is_bne   = (op == OP_BNE);
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            default: ;
        endcase
        // r0 is hardwired, so a write to it must never look like a producer.
        if (ctrl.waddr == '0)
            ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control and hazard unit: ID decode, ID/EX-EX/MEM-MEM/WB bundle registers,
// load-use / RAW stall, forwarding selects and EX-stage redirect with flush.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN   = 1'b1,
    parameter int ALU_OP_W = 6,
    parameter int REG_AW   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         id_instr,
    input  logic                ex_cond,
    output logic                id_s_ext,
    output logic                stall,
    output logic                flush,
    output logic                ex_redirect,
    output logic [1:0]          ex_s_npc,
    output logic [ALU_OP_W-1:0] ex_alu_ctrl,
    output logic                ex_s_b,
    output logic [1:0]          ex_fwd_a,
    output logic [1:0]          ex_fwd_b,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic [1:0]          wb_s_data_write,
    output logic [REG_AW-1:0]   wb_waddr
);

    ctrl_t           id_ctrl;
    ctrl_t           ex_ctrl;
    ctrl_t           mem_ctrl;
    ctrl_t           wb_ctrl;
    logic            use_rs;
    logic            use_rt;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [1:0]      fwd_a_q;
    logic [1:0]      fwd_b_q;
    logic            load_use;
    logic            raw_any;
    logic            branch_taken;
    logic            unused_ctrl;

    ctrl_decode u_decode (
        .instr  (id_instr),
        .ctrl   (id_ctrl),
        .s_ext  (id_s_ext),
        .use_rs (use_rs),
        .use_rt (use_rt)
    );

    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN) begin
            fwd_a = fwd_sel(rs, ex_ctrl, mem_ctrl);
            fwd_b = fwd_sel(rt, ex_ctrl, mem_ctrl);
        end
    end

    assign load_use = ex_ctrl.is_load && ex_ctrl.waddr != '0 &&
                      ((use_rs && ex_ctrl.waddr == rs) || (use_rt && ex_ctrl.waddr == rt));

    // Without forwarding the register file is read before WB writes it, so WB counts too.
    assign raw_any = src_hit(use_rs, rs, ex_ctrl)  || src_hit(use_rt, rt, ex_ctrl)  ||
                     src_hit(use_rs, rs, mem_ctrl) || src_hit(use_rt, rt, mem_ctrl) ||
                     src_hit(use_rs, rs, wb_ctrl)  || src_hit(use_rt, rt, wb_ctrl);

    assign branch_taken = ex_ctrl.is_bne ? ~ex_cond : ex_cond;
    assign ex_redirect  = (ex_ctrl.s_npc == NPC_JUMP) || (ex_ctrl.s_npc == NPC_JR) ||
                          (ex_ctrl.s_npc == NPC_BR && branch_taken);
    assign flush        = ex_redirect;
    assign stall        = (FWD_EN ? load_use : raw_any) && !ex_redirect;

    // Reset wins over stall/flush; stall and redirect both drop a bubble into ID/EX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_ctrl  <= BUBBLE;
            mem_ctrl <= BUBBLE;
            wb_ctrl  <= BUBBLE;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
        end else begin
            if (stall || ex_redirect) begin
                ex_ctrl <= BUBBLE;
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end else begin
                ex_ctrl <= id_ctrl;
                fwd_a_q <= fwd_a;
                fwd_b_q <= fwd_b;
            end
            mem_ctrl <= ex_ctrl;
            wb_ctrl  <= mem_ctrl;
        end
    end

    assign ex_s_npc        = ex_ctrl.s_npc;
    assign ex_alu_ctrl     = ALU_OP_W'(ex_ctrl.alu_ctrl);
    assign ex_s_b          = ex_ctrl.s_b;
    assign ex_fwd_a        = fwd_a_q;
    assign ex_fwd_b        = fwd_b_q;
    assign mem_write       = mem_ctrl.mem_write;
    assign wb_reg_write    = wb_ctrl.reg_write;
    assign wb_s_data_write = wb_ctrl.s_data_write;
    assign wb_waddr        = REG_AW'(wb_ctrl.waddr);

    assign unused_ctrl = ^{wb_ctrl.mem_write, wb_ctrl.is_load, wb_ctrl.is_bne, wb_ctrl.s_b,
                           wb_ctrl.s_npc, wb_ctrl.alu_ctrl};

endmodule
